// File: rtl/counter_updown_mod_m_if.sv
// Bundle of count-control inputs and count/status outputs for counter_updown_mod_m.
// M must match the M of the counter the interface connects to, so d and Q line up.
interface counter_updown_mod_m_if #(
  parameter int M = 10
);
  localparam int N = ($clog2(M) < 1) ? 1 : $clog2(M);

  logic         enable;
  logic         up_dn;
  logic         load;
  logic [N-1:0] d;
  logic [N-1:0] Q;
  logic         tc;
  logic         wrap;
  logic         load_err;

  modport master (
    output enable, up_dn, load, d,
    input  Q, tc, wrap, load_err
  );

  modport slave (
    input  enable, up_dn, load, d,
    output Q, tc, wrap, load_err
  );
endinterface

// File: rtl/counter_updown_mod_m.sv
// Modulo-M up/down counter with parallel load, wrap or saturate at the limits,
// combinational terminal count for cascading, and registered wrap/load-error pulses.
module counter_updown_mod_m #(
  parameter int M    = 10,
  parameter bit WRAP = 1'b1
) (
  input  logic                  clk,
  input  logic                  sclr,
  counter_updown_mod_m_if.slave bus
);
  localparam int N = ($clog2(M) < 1) ? 1 : $clog2(M);
  localparam logic [N-1:0] Q_MAX = N'(M - 1);
  localparam logic [N:0]   M_EXT = (N + 1)'(M);

  logic [N-1:0] q_q, q_d;
  logic         wrap_q, wrap_d;
  logic         load_err_q, load_err_d;
  logic         at_max, at_min, d_oob;

  // Limit detection and terminal count; tc is purely combinational so a
  // downstream stage sees its carry-in in the same cycle.
  always_comb begin
    at_max = (q_q == Q_MAX);
    at_min = (q_q == '0);
    d_oob  = ({1'b0, bus.d} >= M_EXT);
    bus.tc = bus.enable & ((bus.up_dn & at_max) | (~bus.up_dn & at_min));
  end

  // Next count and status pulses: load beats enable; pulses default low.
  always_comb begin
    q_d        = q_q;
    wrap_d     = 1'b0;
    load_err_d = 1'b0;
    if (bus.load) begin
      if (d_oob) begin
        q_d        = '0;
        load_err_d = 1'b1;
      end else begin
        q_d = bus.d;
      end
    end else if (bus.enable) begin
      if (bus.up_dn) begin
        if (!at_max) begin
          q_d = q_q + N'(1);
        end else if (WRAP) begin
          q_d    = '0;
          wrap_d = 1'b1;
        end
      end else begin
        if (!at_min) begin
          q_d = q_q - N'(1);
        end else if (WRAP) begin
          q_d    = Q_MAX;
          wrap_d = 1'b1;
        end
      end
    end
  end

  // State register; sclr has top priority over load and enable.
  always_ff @(posedge clk) begin
    if (sclr) begin
      q_q        <= '0;
      wrap_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      q_q        <= q_d;
      wrap_q     <= wrap_d;
      load_err_q <= load_err_d;
    end
  end

  // Registered outputs.
  always_comb begin
    bus.Q        = q_q;
    bus.wrap     = wrap_q;
    bus.load_err = load_err_q;
  end
endmodule

// File: tb/tb_counter_updown_mod_m.sv
// Scoreboard bench for counter_updown_mod_m: several configurations plus a
// two-digit cascade, checked against a behavioural model at every falling edge.
module tb_counter_updown_mod_m;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic sclr0 = 1'b0, sclr1 = 1'b0, sclr2 = 1'b0, sclr3 = 1'b0, sclr4 = 1'b0;

  counter_updown_mod_m_if #(.M(10)) if0 ();
  counter_updown_mod_m_if #(.M(10)) if1 ();
  counter_updown_mod_m_if #(.M(2))  if2 ();
  counter_updown_mod_m_if #(.M(16)) if3 ();
  counter_updown_mod_m_if #(.M(10)) if4 ();
  counter_updown_mod_m_if #(.M(10)) if5 ();

  counter_updown_mod_m #(.M(10), .WRAP(1'b1)) u0 (.clk(clk), .sclr(sclr0), .bus(if0));
  counter_updown_mod_m #(.M(10), .WRAP(1'b0)) u1 (.clk(clk), .sclr(sclr1), .bus(if1));
  counter_updown_mod_m #(.M(2),  .WRAP(1'b1)) u2 (.clk(clk), .sclr(sclr2), .bus(if2));
  counter_updown_mod_m #(.M(16), .WRAP(1'b1)) u3 (.clk(clk), .sclr(sclr3), .bus(if3));
  counter_updown_mod_m #(.M(10), .WRAP(1'b1)) u4 (.clk(clk), .sclr(sclr4), .bus(if4));
  counter_updown_mod_m #(.M(10), .WRAP(1'b1)) u5 (.clk(clk), .sclr(sclr4), .bus(if5));

  assign if5.enable = if4.tc;

  typedef struct {
    int    id;
    int    q;
    bit    tc;
    bit    w;
    bit    e;
    string tag;
  } exp_t;

  exp_t  sb[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  string cur_test = "init";

  int mm[6] = '{10, 10, 2, 16, 10, 10};
  bit ww[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
  int mq[6];
  bit mw[6];
  bit me[6];
  bit mv[6] = '{default: 1'b0};

  function automatic bit model_tc(int id, bit en, bit up);
    return en && ((up && mq[id] == mm[id] - 1) || (!up && mq[id] == 0));
  endfunction

  task automatic push_and_update(input int id, input bit s, input bit en, input bit up,
                                 input bit ld, input int dv);
    exp_t x;
    if (mv[id]) begin
      x.id = id; x.q = mq[id]; x.tc = model_tc(id, en, up);
      x.w = mw[id]; x.e = me[id]; x.tag = cur_test;
      sb.push_back(x);
    end
    if (s) begin
      mq[id] = 0; mw[id] = 1'b0; me[id] = 1'b0; mv[id] = 1'b1;
    end else if (ld) begin
      mw[id] = 1'b0;
      if (dv < mm[id]) begin mq[id] = dv; me[id] = 1'b0; end
      else begin mq[id] = 0; me[id] = 1'b1; end
    end else if (en) begin
      me[id] = 1'b0;
      mw[id] = 1'b0;
      if (up) begin
        if (mq[id] < mm[id] - 1) mq[id] = mq[id] + 1;
        else if (ww[id]) begin mq[id] = 0; mw[id] = 1'b1; end
      end else begin
        if (mq[id] > 0) mq[id] = mq[id] - 1;
        else if (ww[id]) begin mq[id] = mm[id] - 1; mw[id] = 1'b1; end
      end
    end else begin
      mw[id] = 1'b0; me[id] = 1'b0;
    end
  endtask

  // One clock of stimulus: target DUT gets the given inputs, all others idle.
  task automatic step(input int tid, input bit s, input bit en, input bit up,
                      input bit ld, input int dv);
    bit si[5], ei[5], ui[5], li[5];
    int di[5];
    bit tc4;
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      si[i] = 1'b0; ei[i] = 1'b0; ui[i] = 1'b0; li[i] = 1'b0; di[i] = 0;
    end
    si[tid] = s; ei[tid] = en; ui[tid] = up; li[tid] = ld; di[tid] = dv;
    sclr0 = si[0]; if0.enable = ei[0]; if0.up_dn = ui[0]; if0.load = li[0]; if0.d = 4'(di[0]);
    sclr1 = si[1]; if1.enable = ei[1]; if1.up_dn = ui[1]; if1.load = li[1]; if1.d = 4'(di[1]);
    sclr2 = si[2]; if2.enable = ei[2]; if2.up_dn = ui[2]; if2.load = li[2]; if2.d = 1'(di[2]);
    sclr3 = si[3]; if3.enable = ei[3]; if3.up_dn = ui[3]; if3.load = li[3]; if3.d = 4'(di[3]);
    sclr4 = si[4]; if4.enable = ei[4]; if4.up_dn = ui[4]; if4.load = li[4]; if4.d = 4'(di[4]);
    for (int i = 0; i < 4; i++) push_and_update(i, si[i], ei[i], ui[i], li[i], di[i]);
    tc4 = model_tc(4, ei[4], ui[4]);
    push_and_update(4, si[4], ei[4], ui[4], li[4], di[4]);
    push_and_update(5, si[4], tc4, 1'b1, 1'b0, 0);
  endtask

  // Monitor: at each falling edge, compare every queued expectation.
  always @(negedge clk) begin
    exp_t x;
    int   aq;
    bit   atc, aw, ae;
    while (sb.size() > 0) begin
      x = sb.pop_front();
      case (x.id)
        0: begin aq = int'(if0.Q); atc = if0.tc; aw = if0.wrap; ae = if0.load_err; end
        1: begin aq = int'(if1.Q); atc = if1.tc; aw = if1.wrap; ae = if1.load_err; end
        2: begin aq = int'(if2.Q); atc = if2.tc; aw = if2.wrap; ae = if2.load_err; end
        3: begin aq = int'(if3.Q); atc = if3.tc; aw = if3.wrap; ae = if3.load_err; end
        4: begin aq = int'(if4.Q); atc = if4.tc; aw = if4.wrap; ae = if4.load_err; end
        default: begin aq = int'(if5.Q); atc = if5.tc; aw = if5.wrap; ae = if5.load_err; end
      endcase
      n_cmp++;
      if (aq !== x.q || atc !== x.tc || aw !== x.w || ae !== x.e) begin
        n_bad++;
        $display("FAIL %s dut%0d @%0t: got Q=%0d tc=%0b wrap=%0b load_err=%0b, expected Q=%0d tc=%0b wrap=%0b load_err=%0b",
                 x.tag, x.id, $time, aq, atc, aw, ae, x.q, x.tc, x.w, x.e);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    if0.enable = 0; if0.up_dn = 0; if0.load = 0; if0.d = '0;
    if1.enable = 0; if1.up_dn = 0; if1.load = 0; if1.d = '0;
    if2.enable = 0; if2.up_dn = 0; if2.load = 0; if2.d = '0;
    if3.enable = 0; if3.up_dn = 0; if3.load = 0; if3.d = '0;
    if4.enable = 0; if4.up_dn = 0; if4.load = 0; if4.d = '0;
    if5.up_dn = 1'b1; if5.load = 1'b0; if5.d = '0;

    // Reset every DUT first so idle ones are checked from here on.
    cur_test = "reset";
    for (int i = 0; i < 5; i++) step(i, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);

    cur_test = "t1_up_wrap";
    step(0, 1, 0, 0, 0, 0);
    repeat (12) step(0, 0, 1, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0);

    cur_test = "t2_down_wrap";
    step(0, 1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    repeat (3) step(0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);

    cur_test = "t2_saturate";
    step(1, 1, 0, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1, 9);
    repeat (2) step(1, 0, 1, 1, 0, 0);
    step(1, 0, 0, 0, 0, 0);

    cur_test = "t3_load";
    step(0, 0, 0, 0, 1, 3);
    step(0, 0, 1, 1, 1, 7);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 1, 1, 12);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 9);
    step(0, 0, 0, 0, 1, 10);
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);

    cur_test = "t4_sclr_priority";
    step(0, 0, 0, 0, 1, 4);
    step(0, 1, 1, 1, 1, 5);
    step(0, 0, 0, 0, 0, 0);
    repeat (6) step(0, 0, 1, 1, 0, 0);
    step(0, 1, 1, 1, 0, 0);
    step(0, 0, 0, 0, 1, 15);
    step(0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);

    cur_test = "t5_cascade";
    step(4, 1, 0, 0, 0, 0);
    repeat (100) step(4, 0, 1, 1, 0, 0);
    repeat (2) step(4, 0, 0, 0, 0, 0);

    cur_test = "t6_m2";
    step(2, 1, 0, 0, 0, 0);
    repeat (5) step(2, 0, 1, 1, 0, 0);
    step(2, 0, 1, 0, 0, 0);
    step(2, 0, 0, 0, 0, 0);

    cur_test = "t6_m16";
    step(3, 1, 0, 0, 0, 0);
    repeat (18) step(3, 0, 1, 1, 0, 0);
    step(3, 0, 1, 0, 0, 0);
    step(3, 0, 1, 0, 0, 0);
    step(3, 0, 1, 0, 0, 0);
    step(3, 0, 0, 0, 1, 15);
    step(3, 0, 0, 0, 0, 0);

    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/counter_updown_mod_m.md
Name: counter_updown_mod_m

Overview:
Parametrised modulo-M counter that can count up or down, load a value in parallel, and wrap or saturate at its limits. Exposes a combinational terminal-count for cascading into the next digit or stage, plus registered wrap and load-error status. It is the general-purpose successor to the simple up-only mod-M counter, for timers, prescalers and BCD/time-of-day digit chains.

Parameters:
M, 10, modulus; count range 0..M-1; legal M >= 2.
WRAP, 1, 1 = wrap at limits (M-1->0 up, 0->M-1 down); 0 = saturate at limits.
N (localparam, not overridable), clog2(M) with minimum 1, counter width; M=10 gives N=4, M=16 gives N=4, M=17 gives N=5.

Ports:
clk  in  1  rising-edge clock
sclr  in  1  synchronous reset, active-high
enable  in  1  count enable (also carry-in when cascaded)
up_dn  in  1  1 = count up, 0 = count down
load  in  1  synchronous parallel load
d  in  N  load value
Q  out  N  current count (registered)
tc  out  1  terminal count, combinational (carry/borrow out)
wrap  out  1  registered one-cycle pulse on a wrap event
load_err  out  1  registered one-cycle pulse on an out-of-range load

Behaviour:
- All state updates occur on the rising edge of clk. Priority order: sclr > load > enable > hold.
- sclr=1: Q<=0, wrap<=0, load_err<=0. Applies regardless of load or enable, including mid-count.
- load=1 (sclr=0), independent of enable:
  - d < M: Q<=d, load_err<=0.
  - d >= M: Q<=0, load_err<=1 for one cycle.
  - wrap<=0.
- enable=1, load=0, up_dn=1:
  - Q < M-1: Q<=Q+1.
  - Q == M-1 and WRAP=1: Q<=0, wrap<=1.
  - Q == M-1 and WRAP=0: Q holds, wrap<=0.
- enable=1, load=0, up_dn=0:
  - Q > 0: Q<=Q-1.
  - Q == 0 and WRAP=1: Q<=M-1, wrap<=1.
  - Q == 0 and WRAP=0: Q holds, wrap<=0.
- enable=0, load=0: Q holds, wrap<=0, load_err<=0.
- wrap and load_err are single-cycle pulses and are cleared in any cycle that does not re-assert them.
- tc is combinational with no reset dependency:
  - tc = enable & ((up_dn & Q==M-1) | (~up_dn & Q==0)).
  - tc asserts in both WRAP modes.
  - Cascading: stage k's tc drives stage k+1's enable, with no extra latency.
- Arithmetic is on N bits. Q never leaves 0..M-1 after reset; when M = 2^N, the M-1 wrap coincides with natural overflow.
- Changing up_dn takes effect on the next edge; there is no pipeline. Count latency is one clock from enable to the Q change.
- Q is undefined before the first sclr; tc and wrap are only meaningful after reset.

Test Plan:
1. M=10, WRAP=1: sclr one cycle, then enable=1, up_dn=1 for 12 cycles -> Q = 0,1,...,9,0,1,2; tc=1 while Q=9; wrap pulses on the cycle after Q=9.
2. M=10, WRAP=1: Q=0, enable=1, up_dn=0 -> Q=9 with wrap=1; tc=1 in the cycle where Q=0. Same stimulus with WRAP=0 -> Q stays 0, wrap stays 0, tc=1.
3. Load precedence: Q=3, enable=1, load=1, d=7 -> Q=7 (no increment). Load d=12 with M=10 -> Q=0, load_err=1 for exactly one cycle.
4. Simultaneous events: sclr=1 together with load=1, d=5, and enable=1 -> Q=0, wrap=0, load_err=0. sclr asserted mid-count at Q=6 -> Q=0 on the next edge.
5. Cascade: two M=10 instances, stage-0 tc driving stage-1 enable, stage-0 enable=1 for 100 cycles -> the pair counts 00..99 and returns to 00; stage-1 increments only on cycles where stage-0 Q=9.
6. Non-power-of-2 and minimum width: M=2 (N=1) up-count toggles 0,1,0 with wrap every 2nd cycle. M=16 (N=4) up-count wraps 15->0 with no illegal value.
